// File: rtl/if_fetch_stage_if.sv
// Instruction-memory fetch bus: request/address out, ack/data back.
// The request and address stay stable until the memory acknowledges.
interface if_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, variable-latency imem handshake,
// one-entry skid buffer for stalls, and the IF/ID pipeline register.
module mux2_1 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);
  assign y = sel ? b : a;
endmodule

module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      stall,
  input  logic                      branch_taken,
  input  logic [31:0]               branch_target,
  if_fetch_stage_if.master          imem,
  output logic [31:0]               if_id_pc,
  output logic [31:0]               if_id_instr,
  output logic                      if_id_valid
);

  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] drop_addr, drop_addr_n;
  logic [31:0] skid_pc, skid_pc_n;
  logic [31:0] skid_instr, skid_instr_n;
  logic [31:0] if_id_pc_n, if_id_instr_n;
  logic        if_id_valid_n;
  logic [31:0] pc_plus4, target_aligned, next_pc;

  assign pc_plus4       = pc + 32'd4;
  assign target_aligned = {branch_target[31:2], 2'b00};

  mux2_1 #(.WIDTH(32)) u_next_pc_mux (
    .a   (pc_plus4),
    .b   (target_aligned),
    .sel (branch_taken),
    .y   (next_pc)
  );

  // A stale request in DROP must keep presenting its original address.
  assign imem.imem_req  = (state != HOLD);
  assign imem.imem_addr = (state == DROP) ? {drop_addr[31:2], 2'b00} : {pc[31:2], 2'b00};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_n       = state;
    pc_n          = pc;
    drop_addr_n   = drop_addr;
    skid_pc_n     = skid_pc;
    skid_instr_n  = skid_instr;
    if_id_pc_n    = if_id_pc;
    if_id_instr_n = if_id_instr;
    if_id_valid_n = if_id_valid;

    if (branch_taken) begin
      pc_n          = next_pc;
      if_id_valid_n = 1'b0;
      if_id_instr_n = NOP_INSTR;
      skid_pc_n     = '0;
      skid_instr_n  = '0;
      unique case (state)
        FETCH: begin
          if (!imem.imem_ack) begin
            state_n     = DROP;
            drop_addr_n = pc;
          end
        end
        HOLD:    state_n = FETCH;
        DROP:    if (imem.imem_ack) state_n = FETCH;
        default: state_n = FETCH;
      endcase
    end else begin
      unique case (state)
        FETCH: begin
          if (imem.imem_ack) begin
            if (!stall) begin
              if_id_pc_n    = pc;
              if_id_instr_n = imem.imem_rdata;
              if_id_valid_n = 1'b1;
              pc_n          = next_pc;
            end else begin
              skid_pc_n    = pc;
              skid_instr_n = imem.imem_rdata;
              state_n      = HOLD;
            end
          end else if (!stall) begin
            if_id_valid_n = 1'b0;
            if_id_instr_n = NOP_INSTR;
          end
        end
        HOLD: begin
          // pc still equals skid_pc here, so next_pc is the skid entry's successor.
          if (!stall) begin
            if_id_pc_n    = skid_pc;
            if_id_instr_n = skid_instr;
            if_id_valid_n = 1'b1;
            pc_n          = next_pc;
            skid_pc_n     = '0;
            skid_instr_n  = '0;
            state_n       = FETCH;
          end
        end
        DROP: begin
          if_id_valid_n = 1'b0;
          if_id_instr_n = NOP_INSTR;
          if (imem.imem_ack) state_n = FETCH;
        end
        default: state_n = FETCH;
      endcase
    end
  end

  // NOTE: the skid buffer is reset too, so an empty buffer never exposes stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      drop_addr   <= '0;
      skid_pc     <= '0;
      skid_instr  <= '0;
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state       <= state_n;
      pc          <= pc_n;
      drop_addr   <= drop_addr_n;
      skid_pc     <= skid_pc_n;
      skid_instr  <= skid_instr_n;
      if_id_pc    <= if_id_pc_n;
      if_id_instr <= if_id_instr_n;
      if_id_valid <= if_id_valid_n;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: streaming, wait states, stall/skid,
// redirect with stale drop, redirect under stall, PC wrap and async reset.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n, rst1_n;
  logic        stall, branch_taken;
  logic [31:0] branch_target;
  logic        ack0;
  logic [31:0] pc0, instr0, pc1, instr1;
  logic        valid0, valid1;

  int n_checks = 0;
  int n_fail   = 0;

  if_fetch_stage_if bus0 ();
  if_fetch_stage_if bus1 ();

  // Memory model: returned instruction is the address with the low bits set.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[31:2], 2'b11};
  endfunction

  assign bus0.imem_ack   = ack0;
  assign bus0.imem_rdata = instr_of(bus0.imem_addr);
  assign bus1.imem_ack   = 1'b1;
  assign bus1.imem_rdata = instr_of(bus1.imem_addr);

  if_fetch_stage u_dut0 (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (bus0.master),
    .if_id_pc      (pc0),
    .if_id_instr   (instr0),
    .if_id_valid   (valid0)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut1 (
    .clk           (clk),
    .rst_n         (rst1_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (bus1.master),
    .if_id_pc      (pc1),
    .if_id_instr   (instr1),
    .if_id_valid   (valid1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_reset0(input string tag);
    check({tag, " req"},   {31'd0, bus0.imem_req}, 32'd1);
    check({tag, " addr"},  bus0.imem_addr, 32'h0);
    check({tag, " valid"}, {31'd0, valid0}, 32'd0);
    check({tag, " pc"},    pc0, 32'h0);
    check({tag, " instr"}, instr0, NOP);
  endtask

  task automatic check_ifid0(input string tag, input logic [31:0] pc, input logic [31:0] addr);
    check({tag, " valid"}, {31'd0, valid0}, 32'd1);
    check({tag, " pc"},    pc0, pc);
    check({tag, " instr"}, instr0, instr_of(pc));
    check({tag, " addr"},  bus0.imem_addr, addr);
  endtask

  task automatic check_bubble0(input string tag, input logic [31:0] addr);
    check({tag, " valid"}, {31'd0, valid0}, 32'd0);
    check({tag, " instr"}, instr0, NOP);
    check({tag, " req"},   {31'd0, bus0.imem_req}, 32'd1);
    check({tag, " addr"},  bus0.imem_addr, addr);
  endtask

  initial begin
    rst_n = 1'b0; rst1_n = 1'b0;
    stall = 1'b0; branch_taken = 1'b0; branch_target = '0; ack0 = 1'b0;

    // Reset state, then streaming with ack tied high.
    step();
    check_reset0("reset");
    rst_n = 1'b1; ack0 = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      check_ifid0($sformatf("stream%0d", k), 32'(4 * (k - 1)), 32'(4 * k));
    end

    // Re-reset, then two wait cycles before the first ack.
    rst_n = 1'b0; ack0 = 1'b0;
    #1;
    check_reset0("rereset");
    step();
    rst_n = 1'b1;
    step(); check_bubble0("wait1", 32'h0);
    step(); check_bubble0("wait2", 32'h0);
    ack0 = 1'b1;
    step(); check_ifid0("wait_ack", 32'h0, 32'h4);

    // Stall on the cycle pc=8 is acked: HOLD, IF/ID frozen, then skid drains.
    step(); check_ifid0("pre_stall", 32'h4, 32'h8);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      ack0 = 1'b0;
      check($sformatf("hold%0d req", k), {31'd0, bus0.imem_req}, 32'd0);
      check($sformatf("hold%0d pc", k), pc0, 32'h4);
      check($sformatf("hold%0d valid", k), {31'd0, valid0}, 32'd1);
    end
    stall = 1'b0;
    step(); check_ifid0("unstall", 32'h8, 32'hC);

    // Redirect while pc=0x10 is outstanding: DROP keeps old address, data discarded.
    ack0 = 1'b1;
    step(); check_ifid0("pre_br", 32'hC, 32'h10);
    ack0 = 1'b0;
    step(); check_bubble0("br_wait", 32'h10);
    branch_taken = 1'b1; branch_target = 32'h0000_0102;
    step(); check_bubble0("drop0", 32'h10);
    branch_taken = 1'b0;
    step(); check_bubble0("drop1", 32'h10);
    ack0 = 1'b1;
    step(); check_bubble0("drop_ack", 32'h100);
    step(); check_ifid0("after_drop", 32'h100, 32'h104);

    // Redirect together with stall while IF/ID is valid.
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0203;
    step(); check_bubble0("br_stall", 32'h200);
    stall = 1'b0; branch_taken = 1'b0;
    step(); check_ifid0("br_stall_next", 32'h200, 32'h204);

    // Asynchronous reset while waiting on a request.
    ack0 = 1'b0;
    step(); check_bubble0("pre_rst", 32'h204);
    #2 rst_n = 1'b0;
    #1 check_reset0("mid_rst");

    // PC wrap on the second instance.
    check("wrap reset addr", bus1.imem_addr, 32'hFFFF_FFFC);
    step();
    rst1_n = 1'b1;
    step();
    check("wrap1 addr", bus1.imem_addr, 32'h0000_0000);
    check("wrap1 pc", pc1, 32'hFFFF_FFFC);
    check("wrap1 valid", {31'd0, valid1}, 32'd1);
    step();
    check("wrap2 addr", bus1.imem_addr, 32'h0000_0004);
    check("wrap2 pc", pc1, 32'h0000_0000);
    check("wrap2 instr", instr1, instr_of(32'h0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage of the 5-stage RISC-V core. It owns the PC register and issues word fetches to instruction memory over a req/ack handshake with variable latency. It captures returned instructions into the IF/ID pipeline register and honours stall and branch redirect from downstream. Next-PC selection is a 32-bit 2:1 mux (mux2_1) instance: a = pc+4, b = branch_target, sel = branch_taken.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, value driven on if_id_instr when if_id_valid=0 (addi x0,x0,0).

Ports:
clk  input  1  core clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
stall  input  1  hazard unit: hold IF/ID and PC.
branch_taken  input  1  EX redirect. Also flushes IF/ID.
branch_target  input  32  redirect address; bits [1:0] forced to 0 internally.
imem_req  output  1  fetch request valid.
imem_addr  output  32  fetch address, word-aligned.
imem_ack  input  1  memory returns imem_rdata this cycle (only meaningful while imem_req=1).
imem_rdata  input  32  fetched instruction.
if_id_pc  output  32  PC of the instruction in IF/ID.
if_id_instr  output  32  instruction in IF/ID.
if_id_valid  output  1  IF/ID holds a real instruction.

Behaviour:
- Reset (asynchronous, rst_n=0): pc=RESET_PC, state=FETCH, if_id_valid=0, if_id_pc=0, if_id_instr=NOP_INSTR, skid buffer empty.
- imem_req is combinational: 1 in FETCH and DROP, 0 in HOLD. imem_addr=pc. Both hold stable until ack.
- State FETCH:
  - No ack: if !stall, IF/ID loads a bubble (valid=0, instr=NOP_INSTR). If stall, IF/ID holds.
  - Ack, !stall: IF/ID <= {pc, imem_rdata, valid=1}; pc <= pc+4. Single-cycle throughput when ack is held high.
  - Ack, stall: imem_rdata and pc go into the skid buffer; go to HOLD; pc unchanged.
- State HOLD: no request. IF/ID holds while stall=1. When stall=0: IF/ID <= skid {pc, instr, valid=1}; pc <= pc+4; go to FETCH.
- State DROP: an outstanding request became stale after a redirect. Keep imem_req=1 with the old address until ack. On ack, discard the data and go to FETCH (which fetches the new pc). IF/ID loads a bubble each cycle.
- Redirect (branch_taken=1), highest priority, any state:
  - pc <= {branch_target[31:2], 2'b00}.
  - IF/ID <= bubble, even if stall=1.
  - Skid buffer cleared.
  - From FETCH without ack: go to DROP.
  - From FETCH with ack, or from HOLD: go to FETCH, and the returned data is discarded.
  - From DROP without ack: stay in DROP; with ack: go to FETCH.
- stall never blocks a redirect. stall is otherwise ignored in DROP.
- pc+4 wraps modulo 2^32: 32'hFFFF_FFFC goes to 32'h0000_0000.
- imem_addr[1:0] is always 2'b00.
- Reset asserted mid-request: all state is cleared immediately; any in-flight ack after release is not expected. Memory must drop pending requests when reset is asserted.
- Latency: an instruction acked in cycle N appears on the IF/ID outputs in cycle N+1, absent stall.

Test Plan:
- Reset release, imem_ack tied 1, rdata=addr: imem_addr sequence 0,4,8,C. if_id_pc/if_id_instr trail by one cycle; if_id_valid=1 from the 2nd cycle.
- Ack at cycle 3 only (2-cycle wait): imem_addr stays 0 for 3 cycles; bubbles (valid=0, instr=32'h13) until the instr at pc 0 lands; the next fetch is addr 4.
- stall=1 on the cycle of ack at pc=8 for 3 cycles: state HOLD, imem_req=0, IF/ID frozen. After release, IF/ID shows pc=8 and imem_addr=C.
- branch_taken with branch_target=32'h0000_0102 while waiting on the request for pc=10: DROP until ack; stale data discarded; next imem_addr=32'h100; no valid IF/ID for pc=10.
- branch_taken and stall together with IF/ID valid: IF/ID becomes a bubble, pc=target, and the stall does not block the redirect.
- RESET_PC=32'hFFFF_FFFC, ack tied 1: fetch addresses FFFF_FFFC, then 0000_0000. Asserting rst_n=0 mid-wait returns every output to its reset value the same cycle.
